env_monitor_seq: RTL and testbench

Clocked, parametrised successor to the combinational monitor_conditions threshold check. It watches NUM_CH unsigned sensor channels (e.g. temperature, humidity, pressure) against per-channel high thresholds, with hysteresis and consecutive-sample debounce. It produces per-channel alarm levels, a sticky global alert, a first-fault channel index and a saturating alarm-event counter. It sits between the sensor sample framer and the acoustic-link telemetry packer.

---
 rtl/env_monitor_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_env_monitor_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/env_monitor_seq.sv
// env_monitor_seq: clocked multi-channel high-threshold monitor.
// Each channel has a debounced NORMAL/PENDING/ALARM/RECOVER state machine
// with hysteresis on the release side. The block reports per-channel alarm
// levels, a sticky global alert, the first channel to fault since the last
// clear, and a saturating count of alarm entries. All outputs are registered.

module env_monitor_seq #(
   parameter int NUM_CH   = 3,
   parameter int DATA_W   = 16,
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8,
   localparam int ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_valid,
   input  logic [NUM_CH*DATA_W-1:0] sample_data,
   input  logic [NUM_CH*DATA_W-1:0] thr_hi,
   input  logic [NUM_CH*DATA_W-1:0] hyst,
   input  logic [NUM_CH-1:0]        ch_enable,
   input  logic                     alert_clr,
   output logic [NUM_CH-1:0]        ch_alarm,
   output logic                     alert,
   output logic                     first_fault_valid,
   output logic [ID_W-1:0]          first_fault_id,
   output logic [CNT_W-1:0]         alarm_count
);

   // Debounce counter width, entry-count width and saturating-sum width.
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam int EW = $clog2(NUM_CH + 1);
   localparam int SW = CNT_W + EW;

   localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]    CNT_DEB  = CW'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALARM   = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t            state_r [NUM_CH];
   state_t            state_s [NUM_CH];
   logic [CW-1:0]     cnt_r   [NUM_CH];
   logic [CW-1:0]     cnt_s   [NUM_CH];

   logic [NUM_CH-1:0] exceed_s;
   logic [NUM_CH-1:0] clear_s;
   logic [NUM_CH-1:0] enter_s;
   logic [NUM_CH-1:0] alarm_s;
   logic [EW-1:0]     entries_s;
   logic [ID_W-1:0]   lowest_s;
   logic [SW-1:0]     sum_s;
   logic [CNT_W-1:0]  count_s;
   logic              any_enter_s;
   logic              clr_ok_s;
   logic              alert_s;
   logic              ff_valid_s;
   logic [ID_W-1:0]   ff_id_s;

   // Per-channel unsigned compares; the release level saturates at zero,
   // so a hysteresis at or above the threshold can never release an alarm.
   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_cmp
         logic [DATA_W-1:0] smp_s;
         logic [DATA_W-1:0] thr_s;
         logic [DATA_W-1:0] hys_s;
         logic [DATA_W-1:0] floor_s;

         assign smp_s       = sample_data[g*DATA_W +: DATA_W];
         assign thr_s       = thr_hi[g*DATA_W +: DATA_W];
         assign hys_s       = hyst[g*DATA_W +: DATA_W];
         assign floor_s     = (hys_s >= thr_s) ? {DATA_W{1'b0}} : (thr_s - hys_s);
         assign exceed_s[g] = (smp_s > thr_s);
         assign clear_s[g]  = (hys_s < thr_s) && (smp_s < floor_s);
      end
   endgenerate

   // Channel state and debounce counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_r[i] <= ST_NORMAL;
            cnt_r[i]   <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_r[i] <= state_s[i];
            cnt_r[i]   <= cnt_s[i];
         end
      end
   end

   // Next-state logic: disable overrides everything, otherwise advance only on a sample strobe.
   always_comb begin
      enter_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         state_s[i] = state_r[i];
         cnt_s[i]   = cnt_r[i];
         if (!ch_enable[i]) begin
            state_s[i] = ST_NORMAL;
            cnt_s[i]   = CNT_ZERO;
         end else if (sample_valid) begin
            case (state_r[i])
               ST_NORMAL: begin
                  if (exceed_s[i]) begin
                     if (DEBOUNCE == 1) begin
                        state_s[i] = ST_ALARM;
                        cnt_s[i]   = CNT_ZERO;
                        enter_s[i] = 1'b1;
                     end else begin
                        state_s[i] = ST_PENDING;
                        cnt_s[i]   = CNT_ONE;
                     end
                  end else begin
                     state_s[i] = ST_NORMAL;
                     cnt_s[i]   = CNT_ZERO;
                  end
               end
               ST_PENDING: begin
                  if (exceed_s[i]) begin
                     if ((cnt_r[i] + CNT_ONE) == CNT_DEB) begin
                        state_s[i] = ST_ALARM;
                        cnt_s[i]   = CNT_ZERO;
                        enter_s[i] = 1'b1;
                     end else begin
                        state_s[i] = ST_PENDING;
                        cnt_s[i]   = cnt_r[i] + CNT_ONE;
                     end
                  end else begin
                     state_s[i] = ST_NORMAL;
                     cnt_s[i]   = CNT_ZERO;
                  end
               end
               ST_ALARM: begin
                  if (clear_s[i]) begin
                     if (DEBOUNCE == 1) begin
                        state_s[i] = ST_NORMAL;
                        cnt_s[i]   = CNT_ZERO;
                     end else begin
                        state_s[i] = ST_RECOVER;
                        cnt_s[i]   = CNT_ONE;
                     end
                  end else begin
                     state_s[i] = ST_ALARM;
                     cnt_s[i]   = CNT_ZERO;
                  end
               end
               ST_RECOVER: begin
                  if (clear_s[i]) begin
                     if ((cnt_r[i] + CNT_ONE) == CNT_DEB) begin
                        state_s[i] = ST_NORMAL;
                        cnt_s[i]   = CNT_ZERO;
                     end else begin
                        state_s[i] = ST_RECOVER;
                        cnt_s[i]   = cnt_r[i] + CNT_ONE;
                     end
                  end else begin
                     state_s[i] = ST_ALARM;
                     cnt_s[i]   = CNT_ZERO;
                  end
               end
               default: begin
                  state_s[i] = ST_NORMAL;
                  cnt_s[i]   = CNT_ZERO;
               end
            endcase
         end else begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
         end
      end
   end

   // Output decode: alarm levels, entry count, lowest entering index, alert and first-fault updates.
   always_comb begin
      alarm_s   = {NUM_CH{1'b0}};
      entries_s = {EW{1'b0}};
      lowest_s  = {ID_W{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         alarm_s[i] = (state_s[i] == ST_ALARM) || (state_s[i] == ST_RECOVER);
         if (enter_s[i]) begin
            entries_s = entries_s + EW'(1);
            lowest_s  = ID_W'(i);
         end else begin
            entries_s = entries_s;
            lowest_s  = lowest_s;
         end
      end

      any_enter_s = |enter_s;
      clr_ok_s    = alert_clr && !(|alarm_s);

      sum_s   = SW'(alarm_count) + SW'(entries_s);
      count_s = (sum_s > SW'(CNT_MAX)) ? CNT_MAX : sum_s[CNT_W-1:0];

      if (any_enter_s) begin
         alert_s = 1'b1;
      end else if (clr_ok_s) begin
         alert_s = 1'b0;
      end else begin
         alert_s = alert;
      end

      if (any_enter_s && (!first_fault_valid || alert_clr)) begin
         ff_valid_s = 1'b1;
         ff_id_s    = lowest_s;
      end else if (clr_ok_s) begin
         ff_valid_s = 1'b0;
         ff_id_s    = {ID_W{1'b0}};
      end else begin
         ff_valid_s = first_fault_valid;
         ff_id_s    = first_fault_id;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_alarm          <= {NUM_CH{1'b0}};
         alert             <= 1'b0;
         first_fault_valid <= 1'b0;
         first_fault_id    <= {ID_W{1'b0}};
         alarm_count       <= {CNT_W{1'b0}};
      end else begin
         ch_alarm          <= alarm_s;
         alert             <= alert_s;
         first_fault_valid <= ff_valid_s;
         first_fault_id    <= ff_id_s;
         alarm_count       <= count_s;
      end
   end

endmodule

// File: tb/tb_env_monitor_seq.sv
// Self-checking bench for env_monitor_seq (3 channels, debounce 4, 8-bit counter).
// The reference model tracks, per channel, only an alarm flag and a run length
// of consecutive qualifying samples.

module tb_env_monitor_seq;

   localparam int NCH = 3;
   localparam int DW  = 16;
   localparam int DEB = 4;
   localparam int CW  = 8;
   localparam int IW  = 2;
   localparam int CMAX = 255;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sample_valid;
   logic [NCH*DW-1:0] sample_data;
   logic [NCH*DW-1:0] thr_hi;
   logic [NCH*DW-1:0] hyst;
   logic [NCH-1:0]    ch_enable;
   logic              alert_clr;
   logic [NCH-1:0]    ch_alarm;
   logic              alert;
   logic              first_fault_valid;
   logic [IW-1:0]     first_fault_id;
   logic [CW-1:0]     alarm_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [NCH-1:0] m_alarm;
   int             m_run [NCH];
   logic           m_alert;
   logic           m_ffv;
   logic [IW-1:0]  m_ffid;
   int             m_count;

   env_monitor_seq #(.NUM_CH(NCH), .DATA_W(DW), .DEBOUNCE(DEB), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .thr_hi(thr_hi), .hyst(hyst), .ch_enable(ch_enable), .alert_clr(alert_clr),
      .ch_alarm(ch_alarm), .alert(alert), .first_fault_valid(first_fault_valid),
      .first_fault_id(first_fault_id), .alarm_count(alarm_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_alarm = '0; m_alert = 1'b0; m_ffv = 1'b0; m_ffid = '0; m_count = 0;
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
   endtask

   // One clock of the reference model, using the inputs currently applied.
   task automatic model_step();
      int entries;
      int lowest;
      entries = 0;
      lowest  = -1;
      for (int i = 0; i < NCH; i++) begin
         int s, t, h, fl;
         logic exc, clr;
         s = int'(sample_data[i*DW +: DW]);
         t = int'(thr_hi[i*DW +: DW]);
         h = int'(hyst[i*DW +: DW]);
         fl  = (t > h) ? t - h : 0;
         exc = (s > t);
         clr = (s < fl);
         if (!ch_enable[i]) begin
            m_alarm[i] = 1'b0; m_run[i] = 0;
         end else if (sample_valid) begin
            if (!m_alarm[i]) begin
               m_run[i] = exc ? m_run[i] + 1 : 0;
               if (m_run[i] == DEB) begin
                  m_alarm[i] = 1'b1; m_run[i] = 0; entries++;
                  if (lowest < 0) lowest = i;
               end
            end else begin
               m_run[i] = clr ? m_run[i] + 1 : 0;
               if (m_run[i] == DEB) begin
                  m_alarm[i] = 1'b0; m_run[i] = 0;
               end
            end
         end
      end
      m_count = (m_count + entries > CMAX) ? CMAX : m_count + entries;
      if (entries > 0) m_alert = 1'b1;
      else if (alert_clr && m_alarm == '0) m_alert = 1'b0;
      if (entries > 0 && (!m_ffv || alert_clr)) begin
         m_ffv = 1'b1; m_ffid = IW'(lowest);
      end else if (alert_clr && m_alarm == '0) begin
         m_ffv = 1'b0; m_ffid = '0;
      end
   endtask

   // Apply one clock with the given strobe; inputs change #1 after the edge.
   task automatic step(input logic v);
      sample_valid = v;
      model_step();
      @(posedge clk); #1;
      sample_valid = 1'b0;
      alert_clr    = 1'b0;
   endtask

   task automatic set_all(input int a, input int b, input int c);
      sample_data[0*DW +: DW] = DW'(a);
      sample_data[1*DW +: DW] = DW'(b);
      sample_data[2*DW +: DW] = DW'(c);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sample_valid = 1'b0; alert_clr = 1'b0;
      ch_enable = 3'b111; set_all(0, 0, 0);
      for (int i = 0; i < NCH; i++) begin
         thr_hi[i*DW +: DW] = 16'd100; hyst[i*DW +: DW] = 16'd10;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ch_alarm !== 3'b000) begin errors++; $display("FAIL reset_alarm got=%b exp=000", ch_alarm); end
      checks++; if (alert !== 1'b0) begin errors++; $display("FAIL reset_alert got=%b exp=0", alert); end
      checks++; if (first_fault_valid !== 1'b0 || first_fault_id !== 2'd0) begin errors++; $display("FAIL reset_ff got=%b/%0d exp=0/0", first_fault_valid, first_fault_id); end
      checks++; if (alarm_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", alarm_count); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_equal_break();
      int seq [4] = '{101, 101, 100, 101};
      for (int k = 0; k < 4; k++) begin
         set_all(seq[k], 0, 0);
         step(1'b1);
      end
      checks++; if (ch_alarm !== 3'b000) begin errors++; $display("FAIL equal_break_alarm got=%b exp=000", ch_alarm); end
      checks++; if (alarm_count !== 8'd0) begin errors++; $display("FAIL equal_break_count got=%0d exp=0", alarm_count); end
   endtask

   task automatic test_basic_alarm();
      set_all(0, 0, 0); step(1'b1);
      set_all(101, 0, 0);
      for (int k = 0; k < 4; k++) begin
         checks++; if (ch_alarm !== 3'b000) begin errors++; $display("FAIL basic_early k=%0d got=%b exp=000", k, ch_alarm); end
         step(1'b1);
         step(1'b0);   // idle cycle must not advance debounce
      end
      checks++; if (ch_alarm !== 3'b001) begin errors++; $display("FAIL basic_alarm got=%b exp=001", ch_alarm); end
      checks++; if (alert !== 1'b1) begin errors++; $display("FAIL basic_alert got=%b exp=1", alert); end
      checks++; if (first_fault_valid !== 1'b1 || first_fault_id !== 2'd0) begin errors++; $display("FAIL basic_ff got=%b/%0d exp=1/0", first_fault_valid, first_fault_id); end
      checks++; if (alarm_count !== 8'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", alarm_count); end
   endtask

   task automatic test_hysteresis();
      set_all(95, 0, 0);
      repeat (4) step(1'b1);
      checks++; if (ch_alarm !== 3'b001) begin errors++; $display("FAIL hyst_hold got=%b exp=001", ch_alarm); end
      set_all(89, 0, 0);
      repeat (3) step(1'b1);
      checks++; if (ch_alarm !== 3'b001) begin errors++; $display("FAIL hyst_early got=%b exp=001", ch_alarm); end
      step(1'b1);
      checks++; if (ch_alarm !== 3'b000) begin errors++; $display("FAIL hyst_release got=%b exp=000", ch_alarm); end
      checks++; if (alert !== 1'b1) begin errors++; $display("FAIL hyst_sticky got=%b exp=1", alert); end
      alert_clr = 1'b1; step(1'b0);
      checks++; if (alert !== 1'b0 || first_fault_valid !== 1'b0) begin errors++; $display("FAIL hyst_clr got=%b/%b exp=0/0", alert, first_fault_valid); end
      checks++; if (alarm_count !== 8'd1) begin errors++; $display("FAIL hyst_count got=%0d exp=1", alarm_count); end
   endtask

   task automatic test_back_to_back();
      set_all(0, 101, 101);
      repeat (4) step(1'b1);
      checks++; if (ch_alarm !== 3'b110) begin errors++; $display("FAIL b2b_alarm got=%b exp=110", ch_alarm); end
      checks++; if (first_fault_id !== 2'd1 || first_fault_valid !== 1'b1) begin errors++; $display("FAIL b2b_ffid got=%b/%0d exp=1/1", first_fault_valid, first_fault_id); end
      checks++; if (alarm_count !== 8'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", alarm_count); end
      set_all(0, 0, 101);
      repeat (4) step(1'b1);
      alert_clr = 1'b1; step(1'b0);
      checks++; if (ch_alarm !== 3'b100 || alert !== 1'b1) begin errors++; $display("FAIL b2b_clr_blocked got=%b/%b exp=100/1", ch_alarm, alert); end
      checks++; if (first_fault_id !== 2'd1 || first_fault_valid !== 1'b1) begin errors++; $display("FAIL b2b_ff_hold got=%b/%0d exp=1/1", first_fault_valid, first_fault_id); end
      set_all(0, 0, 0);
      repeat (4) step(1'b1);
      alert_clr = 1'b1; step(1'b0);
      checks++; if (alert !== 1'b0 || first_fault_valid !== 1'b0) begin errors++; $display("FAIL b2b_clr got=%b/%b exp=0/0", alert, first_fault_valid); end
   endtask

   task automatic test_disable_and_reset();
      set_all(101, 0, 0);
      repeat (4) step(1'b1);
      checks++; if (ch_alarm !== 3'b001 || alarm_count !== 8'd4) begin errors++; $display("FAIL dis_pre got=%b/%0d exp=001/4", ch_alarm, alarm_count); end
      ch_enable = 3'b110; step(1'b0);
      checks++; if (ch_alarm !== 3'b000) begin errors++; $display("FAIL dis_drop got=%b exp=000", ch_alarm); end
      checks++; if (alarm_count !== 8'd4) begin errors++; $display("FAIL dis_count got=%0d exp=4", alarm_count); end
      ch_enable = 3'b111;
      set_all(0, 101, 0);
      repeat (2) step(1'b1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (ch_alarm !== 3'b000 || alert !== 1'b0 || first_fault_valid !== 1'b0 || first_fault_id !== 2'd0 || alarm_count !== 8'd0) begin
         errors++; $display("FAIL mid_reset got=%b/%b/%b/%0d/%0d exp=0", ch_alarm, alert, first_fault_valid, first_fault_id, alarm_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_all(0, 101, 0);
      repeat (3) step(1'b1);
      checks++; if (ch_alarm !== 3'b000) begin errors++; $display("FAIL post_reset_debounce got=%b exp=000", ch_alarm); end
      step(1'b1);
      checks++; if (ch_alarm !== 3'b010) begin errors++; $display("FAIL post_reset_alarm got=%b exp=010", ch_alarm); end
   endtask

   task automatic test_saturation();
      for (int r = 0; r < 90; r++) begin
         set_all(101, 101, 101);
         repeat (4) step(1'b1);
         checks++; if (alarm_count !== CW'(m_count)) begin errors++; $display("FAIL sat_track r=%0d got=%0d exp=%0d", r, alarm_count, m_count); end
         ch_enable = 3'b000; step(1'b0);
         ch_enable = 3'b111;
      end
      checks++; if (alarm_count !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", alarm_count); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 31) == 0) begin
            for (int i = 0; i < NCH; i++) begin
               thr_hi[i*DW +: DW] = DW'($urandom_range(60, 140));
               hyst[i*DW +: DW]   = DW'($urandom_range(0, 150));
            end
         end
         for (int i = 0; i < NCH; i++) begin
            sample_data[i*DW +: DW] = DW'($urandom_range(30, 170));
            ch_enable[i] = ($urandom_range(0, 15) != 0);
         end
         alert_clr = ($urandom_range(0, 7) == 0);
         step($urandom_range(0, 3) != 0);
         checks++; if (ch_alarm !== m_alarm) begin errors++; $display("FAIL rnd_alarm c=%0d got=%b exp=%b", c, ch_alarm, m_alarm); end
         checks++; if (alert !== m_alert) begin errors++; $display("FAIL rnd_alert c=%0d got=%b exp=%b", c, alert, m_alert); end
         checks++; if (first_fault_valid !== m_ffv || first_fault_id !== m_ffid) begin errors++; $display("FAIL rnd_ff c=%0d got=%b/%0d exp=%b/%0d", c, first_fault_valid, first_fault_id, m_ffv, m_ffid); end
         checks++; if (alarm_count !== CW'(m_count)) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, alarm_count, m_count); end
      end
   endtask

   initial begin
      test_reset();
      test_equal_break();
      test_basic_alarm();
      test_hysteresis();
      test_back_to_back();
      test_disable_and_reset();
      test_saturation();
      test_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
